paillier_result_gather: RTL and testbench

PAILLIER_RESULT_GATHER -- requirements
Module: paillier_result_gather

---
 rtl/paillier_result_gather.sv | 204 ++++++++++++++++++++
 tb/tb_paillier_result_gather.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paillier_result_gather.sv
// Gathers fixed-length result bursts from per-channel FIFOs into one output stream.
// Optional macro PAILLIER_GATHER_DROP_CNT_EN adds a saturating drop_cnt output.
module paillier_result_gather #(
  parameter int BLOCK_COUNT = 24,
  parameter int K           = 128,
  parameter int N           = 32,
  parameter int FIFO_AW     = $clog2(2*N)
) (
  input  logic                           M_AXI_ACLK,
  input  logic                           M_AXI_ARESETN,
  input  logic                           start,
  input  logic [BLOCK_COUNT-1:0]         chan_mask,
  input  logic [BLOCK_COUNT-1:0]         in_valid,
  input  logic [BLOCK_COUNT*K-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [K-1:0]                   out_data,
  output logic [$clog2(BLOCK_COUNT)-1:0] out_chan,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic [BLOCK_COUNT-1:0]         overflow
`ifdef PAILLIER_GATHER_DROP_CNT_EN
  ,
  output logic [15:0]                    drop_cnt
`endif
);

  localparam int CW    = $clog2(BLOCK_COUNT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int BW    = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, BURST, FIN} state_t;

  state_t state, state_nxt;

  logic [BLOCK_COUNT-1:0][K-1:0] head;
  logic [BLOCK_COUNT-1:0]        has_burst;
  logic [BLOCK_COUNT-1:0]        drop;
  logic [BLOCK_COUNT-1:0]        mask_q;
  logic [BLOCK_COUNT-1:0]        served;
  logic [BLOCK_COUNT-1:0]        pending;
  logic [BLOCK_COUNT-1:0]        elig;
  logic [CW-1:0]                 sel;
  logic [CW-1:0]                 rr;
  logic [CW-1:0]                 hit_idx;
  logic                          hit;
  logic [BW-1:0]                 beat;
  logic                          xfer;
  logic                          last_xfer;
  logic                          load_task;
  logic                          burst_go;

  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] c);
    return (c == CW'(BLOCK_COUNT-1)) ? '0 : c + CW'(1);
  endfunction

  assign xfer      = (state == BURST) && out_ready;
  assign last_xfer = xfer && (beat == BW'(N-1));

  // Per-channel FIFO: writes land whenever in_valid is high; a read frees the
  // slot in the same cycle so a write to a full FIFO being read is kept.
  for (genvar c = 0; c < BLOCK_COUNT; c++) begin : g_fifo
    logic [K-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] fill;
    logic          full;
    logic          rd_en;
    logic          wr_en;
    logic          ovf;

    assign fill         = wp - rp;
    assign full         = (fill == PW'(DEPTH));
    assign has_burst[c] = (fill >= PW'(N));
    assign rd_en        = xfer && (sel == CW'(c));
    assign drop[c]      = in_valid[c] && full && !rd_en;
    assign wr_en        = in_valid[c] && !drop[c];
    assign head[c]      = mem[rp[FIFO_AW-1:0]];
    assign overflow[c]  = ovf;

    always_ff @(posedge M_AXI_ACLK) begin
      if (wr_en) mem[wp[FIFO_AW-1:0]] <= in_data[c*K +: K];
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
        wp  <= '0;
        rp  <= '0;
        ovf <= 1'b0;
      end else begin
        if (wr_en)   wp  <= wp + PW'(1);
        if (rd_en)   rp  <= rp + PW'(1);
        if (drop[c]) ovf <= 1'b1;
      end
    end
  end

  assign pending = mask_q & ~served;
  assign elig    = pending & has_burst;

  // Round-robin search starting at rr.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      int j;
      j = int'(rr) + i;
      if (j >= BLOCK_COUNT) j = j - BLOCK_COUNT;
      if (!hit && elig[j]) begin
        hit     = 1'b1;
        hit_idx = CW'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load_task = 1'b0;
    burst_go  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_task = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (pending == '0) begin
          state_nxt = FIN;
        end else if (hit) begin
          burst_go  = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (last_xfer) state_nxt = SCAN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state  <= IDLE;
      mask_q <= '0;
      served <= '0;
      sel    <= '0;
      rr     <= '0;
      beat   <= '0;
    end else begin
      state <= state_nxt;
      if (load_task) begin
        mask_q <= chan_mask;
        served <= '0;
      end
      if (burst_go) begin
        sel  <= hit_idx;
        beat <= '0;
      end else if (xfer) begin
        beat <= beat + BW'(1);
      end
      if (last_xfer) begin
        served[sel] <= 1'b1;
        rr          <= rr_next(sel);
      end
    end
  end

  // Outputs are gated by state so they read zero whenever not bursting.
  assign out_valid = (state == BURST);
  assign out_data  = (state == BURST) ? head[sel] : '0;
  assign out_chan  = (state == BURST) ? sel : '0;
  assign out_last  = (state == BURST) && (beat == BW'(N-1));
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

`ifdef PAILLIER_GATHER_DROP_CNT_EN
  localparam int DW = $clog2(BLOCK_COUNT+1);

  logic [DW-1:0] drops_now;

  function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [DW-1:0] inc);
    logic [16:0] s;
    s = {1'b0, acc} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    drops_now = '0;
    for (int c = 0; c < BLOCK_COUNT; c++) drops_now = drops_now + DW'(drop[c]);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) drop_cnt <= '0;
    else                drop_cnt <= sat_add(drop_cnt, drops_now);
  end
`endif

endmodule

// File: tb/tb_paillier_result_gather.sv
// Directed bench for paillier_result_gather (BLOCK_COUNT=4, K=128, N=4, FIFO_AW=3).
module tb_paillier_result_gather;
  localparam int BC = 4;
  localparam int K  = 128;
  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [BC-1:0] chan_mask;
  logic [BC-1:0] in_valid;
  logic [BC*K-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_data;
  logic [1:0]    out_chan;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [BC-1:0] overflow;
`ifdef PAILLIER_GATHER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  paillier_result_gather #(.BLOCK_COUNT(BC), .K(K), .N(N), .FIFO_AW(AW)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .start         (start),
    .chan_mask     (chan_mask),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_chan      (out_chan),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
`ifdef PAILLIER_GATHER_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [K-1:0] word(input int ch, input int v);
    return K'((ch << 8) + v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chkb({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_chan"}, K'(out_chan), '0);
    chkb({tag, "_last"}, out_last, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_done"}, done, 1'b0);
    chk({tag, "_ovf"}, K'(overflow), '0);
`ifdef PAILLIER_GATHER_DROP_CNT_EN
    chk({tag, "_dropcnt"}, K'(drop_cnt), '0);
`endif
  endtask

  task automatic push_one(input int ch, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = BC'(1 << ch);
      in_data[ch*K +: K] = word(ch, base + i);
      tick();
    end
    in_valid = '0;
  endtask

  task automatic push_all(input int base);
    for (int i = 0; i < N; i++) begin
      in_valid = '1;
      for (int c = 0; c < BC; c++) in_data[c*K +: K] = word(c, base + i);
      tick();
    end
    in_valid = '0;
  endtask

  task automatic do_start(input logic [BC-1:0] m);
    chan_mask = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic expect_burst(input int ch, input int base);
    int k;
    k = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    for (int i = 0; i < N; i++) begin
      chkb("burst_valid", out_valid, 1'b1);
      chk("burst_data", out_data, word(ch, base + i));
      chk("burst_chan", K'(out_chan), K'(ch));
      chkb("burst_last", out_last, (i == N-1));
      tick();
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 8) begin
      chkb("no_valid_before_done", out_valid, 1'b0);
      tick();
      k++;
    end
    chkb("done_pulse", done, 1'b1);
    tick();
    chkb("done_width", done, 1'b0);
    chkb("busy_clear", busy, 1'b0);
  endtask

  initial begin
    int k;
    rst_n     = 1'b1;
    start     = 1'b0;
    chan_mask = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    tick();
    chk_zero("reset_held");
    rst_n = 1'b1;
    tick();

    // All four channels preloaded, served in channel order
    push_all(0);
    out_ready = 1'b1;
    do_start(4'hF);
    chkb("lat_busy", busy, 1'b1);
    chkb("lat_cycle1", out_valid, 1'b0);
    tick();
    chkb("lat_cycle2", out_valid, 1'b1);
    for (int c = 0; c < BC; c++) expect_burst(c, 0);
    chkb("done_after_last_xfer_0", done, 1'b0);
    tick();
    chkb("done_after_last_xfer_1", done, 1'b1);
    chkb("done_no_valid", out_valid, 1'b0);
    tick();
    chkb("done_once", done, 1'b0);
    chkb("idle_busy", busy, 1'b0);

    // Channel 3 ready before channel 1; rr starts at 0
    push_one(3, 'h10, N);
    do_start(4'b1010);
    expect_burst(3, 'h10);
    chkb("b_wait_busy", busy, 1'b1);
    chkb("b_wait_novalid", out_valid, 1'b0);
    push_one(1, 'h20, N);
    expect_burst(1, 'h20);
    wait_done();

    // rr now points past channel 1, so channel 2 wins over channel 0
    push_one(0, 'h38, N);
    push_one(2, 'h30, N);
    do_start(4'b0101);
    k = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("c_first_chan", K'(out_chan), K'(2));
    chk("c_w0", out_data, word(2, 'h30));
    tick();
    out_ready = 1'b0;
    chk("c_w1", out_data, word(2, 'h31));
    tick();
    chkb("c_hold1_valid", out_valid, 1'b1);
    chk("c_hold1_data", out_data, word(2, 'h31));
    chkb("c_hold1_last", out_last, 1'b0);
    tick();
    chkb("c_hold2_valid", out_valid, 1'b1);
    chk("c_hold2_data", out_data, word(2, 'h31));
    chk("c_hold2_chan", K'(out_chan), K'(2));
    out_ready = 1'b1;
    tick();
    chk("c_w2", out_data, word(2, 'h32));
    tick();
    chk("c_w3", out_data, word(2, 'h33));
    chkb("c_w3_last", out_last, 1'b1);
    tick();
    expect_burst(0, 'h38);
    wait_done();

    // Empty mask completes without output
    do_start(4'h0);
    chkb("e_cycle1_done", done, 1'b0);
    chkb("e_cycle1_busy", busy, 1'b1);
    tick();
    chkb("e_cycle2_done", done, 1'b1);
    chkb("e_cycle2_novalid", out_valid, 1'b0);
    tick();
    chkb("e_after_done", done, 1'b0);
    chkb("e_after_busy", busy, 1'b0);

    // Nine writes into an 8-deep FIFO
    push_one(2, 'h40, 9);
    chk("d_overflow", K'(overflow), K'(4'b0100));
`ifdef PAILLIER_GATHER_DROP_CNT_EN
    chk("d_drop_cnt", K'(drop_cnt), K'(1));
`endif
    do_start(4'b0100);
    expect_burst(2, 'h40);
    wait_done();
    do_start(4'b0100);
    expect_burst(2, 'h44);
    wait_done();
    chk("d_overflow_sticky", K'(overflow), K'(4'b0100));
    do_start(4'b0100);
    for (int i = 0; i < 6; i++) begin
      tick();
      chkb("d_fifo_drained", out_valid, 1'b0);
    end

    // Reset in the middle of a burst
    push_one(2, 'h50, N);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("f_w0", out_data, word(2, 'h50));
    tick();
    chk("f_w1", out_data, word(2, 'h51));
    tick();
    chk("f_w2_shown", out_data, word(2, 'h52));
    rst_n = 1'b0;
    #1 chk_zero("f_reset");
    #3 rst_n = 1'b1;
    tick();
    chkb("f_release_idle", busy, 1'b0);
    do_start(4'hF);
    for (int i = 0; i < 10; i++) begin
      chkb("f_nodata_valid", out_valid, 1'b0);
      chkb("f_nodata_done", done, 1'b0);
      tick();
    end
    chkb("f_still_busy", busy, 1'b1);
    push_all('h60);
    for (int c = 0; c < BC; c++) expect_burst(c, 'h60);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
